mem_stall_ctrl: RTL and testbench

//  Memory-side sequencer downstream of the multicycle CPU: owns its clk_en, services each
//  CPU step's single memory access against a synchronous block RAM (fixed read latency),

---
 rtl/mem_map_pkg.sv | 32 +++
 rtl/mem_stall_ctrl_if.sv | 13 +
 rtl/mmio_regs.sv | 62 ++++++
 rtl/mem_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_stall_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_map_pkg.sv
// Purpose: shared memory-map constants, sequencer state type and address decode helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package mem_map_pkg;

  localparam logic [31:0] IO_BASE_DEF = 32'hFFFF0000;

  // MMIO register offsets relative to the window base
  localparam logic [31:0] IO_LED  = 32'h0000_0000;
  localparam logic [31:0] IO_SW   = 32'h0000_0004;
  localparam logic [31:0] IO_TICK = 32'h0000_0008;

  typedef enum logic [1:0] {
    HALT   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    TICK   = 2'd3
  } state_t;

  // Everything at or above the window base is MMIO; below it is block RAM
  function automatic logic is_io(input logic [31:0] addr, input logic [31:0] base);
    return addr >= base;
  endfunction

  // Word offset into the MMIO window; byte-lane bits are dropped like the RAM path does
  function automatic logic [31:0] io_offset(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return {off[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Purpose: CPU-side memory bus between the multicycle CPU and the memory sequencer.
// Latency: n/a (wires only).
// Backpressure: CPU holds mem_addr/w_data/wr_en until clk_en; clk_en is the only advance.
interface mem_stall_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] w_data;
  logic        wr_en;
  logic        clk_en;
  logic [31:0] r_data;

  modport master (output mem_addr, output w_data, output wr_en, input clk_en, input r_data);
  modport slave  (input mem_addr, input w_data, input wr_en, output clk_en, output r_data);
endinterface

// File: rtl/mmio_regs.sv
// Purpose: LED register, switch synchroniser, free-running step tick counter and MMIO read mux.
// Latency: read mux combinational; led/tick update on the clock after led_we/tick_inc; sw 2 cycles.
// Backpressure: none; strobes are accepted every cycle they are high.
module mmio_regs
  import mem_map_pkg::*;
(
  input  logic        clk_100M,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [31:0] rd_off,
  input  logic        led_we,
  input  logic [15:0] led_wdata,
  input  logic        tick_inc,
  output logic [15:0] led,
  output logic [31:0] rd_data
);

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [31:0] tick_cnt;

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // LED register, written only by a store to the LED offset
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      led <= '0;
    end else if (led_we) begin
      led <= led_wdata;
    end
  end

  // Count of completed CPU steps; wraps naturally at 32 bits
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick_inc) begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

  // Read mux; unmapped offsets return zero
  always_comb begin
    rd_data = '0;
    case (rd_off)
      IO_LED:  rd_data = {16'h0000, led};
      IO_SW:   rd_data = {16'h0000, sw_sync};
      IO_TICK: rd_data = tick_cnt;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Purpose: sequences one memory access per CPU step (RAM or MMIO) and issues the CPU clk_en strobe.
// Latency: one step = RAM_LAT+2 cycles from ACCESS to the clk_en cycle; r_data valid with clk_en.
// Backpressure: CPU stalls between clk_en pulses; run/step gate whether a new step starts.
module mem_stall_ctrl
  import mem_map_pkg::*;
#(
  parameter int          ADDR_W  = 11,
  parameter int          RAM_LAT = 1,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  mem_stall_ctrl_if.slave   cpu,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output logic              halted,
  output logic              misalign
);

  localparam int              CNT_W  = $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(RAM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      r_data_q;
  logic             clk_en_q;
  logic             addr_io;
  logic [31:0]      io_off;
  logic [31:0]      io_rd_data;
  logic             led_we;
  logic             tick_inc;

  assign addr_io = is_io(cpu.mem_addr, IO_BASE);
  assign io_off  = io_offset(cpu.mem_addr, IO_BASE);

  // Bit 28 splits text (0x004...) from data (0x100...) into the two RAM halves
  assign ram_addr  = {cpu.mem_addr[28], cpu.mem_addr[ADDR_W:2]};
  assign ram_wdata = cpu.w_data;

  // RAM strobes decode the state register with the live address: the CPU only
  // presents the next address in the ACCESS cycle, so these cannot be pre-registered.
  assign ram_en = !addr_io && ((state == ACCESS) || ((state == TICK) && cpu.wr_en));
  assign ram_we = !addr_io && (state == TICK) && cpu.wr_en;

  assign led_we   = (state == TICK) && cpu.wr_en && addr_io && (io_off == IO_LED);
  assign tick_inc = (state == TICK);

  assign cpu.clk_en = clk_en_q;
  assign cpu.r_data = r_data_q;

  mmio_regs u_mmio (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .sw        (sw),
    .rd_off    (io_off),
    .led_we    (led_we),
    .led_wdata (cpu.w_data[15:0]),
    .tick_inc  (tick_inc),
    .led       (led),
    .rd_data   (io_rd_data)
  );

  // Step sequencer: HALT -> ACCESS -> WAIT x RAM_LAT -> TICK, with clk_en/halted registered
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      state    <= HALT;
      wait_cnt <= '0;
      r_data_q <= '0;
      clk_en_q <= 1'b0;
      halted   <= 1'b1;
      misalign <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          // run takes precedence, but both lead to the same single access
          if (run || step) begin
            state  <= ACCESS;
            halted <= 1'b0;
          end
        end
        ACCESS: begin
          wait_cnt <= LAT_LD;
          if (cpu.mem_addr[1:0] != 2'b00) begin
            misalign <= 1'b1;
          end
          state <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CNT_ONE) begin
            // Read data is sampled before the store in TICK, so a store to
            // the LED register returns the value it is about to overwrite.
            r_data_q <= addr_io ? io_rd_data : ram_rdata;
            clk_en_q <= 1'b1;
            state    <= TICK;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        TICK: begin
          clk_en_q <= 1'b0;
          if (run) begin
            state <= ACCESS;
          end else begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        default: begin
          state    <= HALT;
          clk_en_q <= 1'b0;
          halted   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Purpose: self-checking bench for mem_stall_ctrl against a CPU-address-level memory/MMIO model.
// Latency: checks step period (RAM_LAT+2) for RAM_LAT=1 and RAM_LAT=3 instances.
// Backpressure: bench acts as the CPU, holding the bus until each clk_en.
module tb_mem_stall_ctrl;

  logic clk_100M = 1'b0;
  logic rst      = 1'b0;
  always #5 clk_100M = ~clk_100M;

  logic        run, step, run3;
  logic [15:0] sw;

  mem_stall_ctrl_if cpu ();
  mem_stall_ctrl_if cpu3 ();

  logic        ram_en, ram_we, halted, misalign;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [15:0] led;

  logic        ram_en3, ram_we3, halted3, misalign3;
  logic [10:0] ram_addr3;
  logic [31:0] ram_wdata3, ram_rdata3;
  logic [15:0] led3;

  mem_stall_ctrl #(.ADDR_W(11), .RAM_LAT(1), .IO_BASE(32'hFFFF0000)) u_dut (
    .clk_100M (clk_100M), .rst (rst), .run (run), .step (step), .cpu (cpu),
    .ram_en (ram_en), .ram_we (ram_we), .ram_addr (ram_addr), .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata), .sw (sw), .led (led), .halted (halted), .misalign (misalign)
  );

  mem_stall_ctrl #(.ADDR_W(11), .RAM_LAT(3), .IO_BASE(32'hFFFF0000)) u_dut3 (
    .clk_100M (clk_100M), .rst (rst), .run (run3), .step (1'b0), .cpu (cpu3),
    .ram_en (ram_en3), .ram_we (ram_we3), .ram_addr (ram_addr3), .ram_wdata (ram_wdata3),
    .ram_rdata (ram_rdata3), .sw (sw), .led (led3), .halted (halted3), .misalign (misalign3)
  );

  // Block RAM models: latency 1 and latency 3, read-before-write
  logic [31:0] ram  [0:2047];
  logic [31:0] ram3 [0:2047];
  logic [31:0] rd_q, s1, s2, s3;
  assign ram_rdata  = rd_q;
  assign ram_rdata3 = s3;

  always @(posedge clk_100M) begin
    if (ram_en) begin
      rd_q <= ram[ram_addr];
      if (ram_we) ram[ram_addr] = ram_wdata;
    end
  end

  always @(posedge clk_100M) begin
    if (ram_en3) begin
      s1 <= ram3[ram_addr3];
      if (ram_we3) ram3[ram_addr3] = ram_wdata3;
    end
    s2 <= s1;
    s3 <= s2;
  end

  int cyc = 0;
  always @(posedge clk_100M) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last_tick = 0;

  // Reference model keyed by word-aligned CPU byte address
  logic [31:0] mdl [logic [31:0]];
  logic [15:0] led_m;
  logic [31:0] tick_m;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w >= 32'hFFFF0000) begin
      case (w - 32'hFFFF0000)
        32'h0:   return {16'h0, led_m};
        32'h4:   return {16'h0, sw};
        32'h8:   return tick_m;
        default: return 32'h0;
      endcase
    end
    return mdl.exists(w) ? mdl[w] : 32'h0;
  endfunction

  task automatic model_commit(input logic [31:0] a, input logic [31:0] wd, input logic we);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (we) begin
      if (w == 32'hFFFF0000) led_m = wd[15:0];
      else if (w < 32'hFFFF0000) mdl[w] = wd;
    end
    tick_m = tick_m + 32'd1;
  endtask

  // Act as the CPU for one step; entered and left #1 after a rising edge
  task automatic cpu_step(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                          input logic pulse, output logic [31:0] rd, output int en_n,
                          output int we_n, output logic [10:0] we_addr, output int t_cyc,
                          output logic seen);
    cpu.mem_addr = addr;
    cpu.w_data   = wd;
    cpu.wr_en    = we;
    en_n = 0; we_n = 0; seen = 1'b0; rd = '0; we_addr = '0; t_cyc = 0;
    if (pulse) begin
      step = 1'b1;
      @(posedge clk_100M); #1;
      step = 1'b0;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_100M);
      if (ram_en) en_n++;
      if (ram_we) begin we_n++; we_addr = ram_addr; end
      if (cpu.clk_en) begin seen = 1'b1; rd = cpu.r_data; t_cyc = cyc; end
    end
    @(posedge clk_100M); #1;
  endtask

  task automatic test_reset();
    run = 1'b0; step = 1'b0; run3 = 1'b0;
    cpu.mem_addr = '0; cpu.w_data = '0; cpu.wr_en = 1'b0;
    cpu3.mem_addr = '0; cpu3.w_data = '0; cpu3.wr_en = 1'b0;
    sw = 16'($urandom);
    led_m = '0; tick_m = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk_100M);
    @(negedge clk_100M);
    checks++; if (cpu.clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got %b want 0", cpu.clk_en); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted got %b want 1", halted); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led got %h want 0000", led); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
    checks++; if (cpu.r_data !== 32'h0) begin errors++; $display("FAIL reset_r_data got %h want 0", cpu.r_data); end
    checks++; if ({ram_en, ram_we} !== 2'b00) begin errors++; $display("FAIL reset_ram_strobes got %b want 00", {ram_en, ram_we}); end
    checks++; if ({halted3, misalign3, ram_we3, led3} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      errors++; $display("FAIL reset_lat3 got %b%b%b %h want 1 0 0 0000", halted3, misalign3, ram_we3, led3);
    end
    @(posedge clk_100M); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk_100M);
    @(negedge clk_100M);
    checks++; if (halted !== 1'b1 || cpu.clk_en !== 1'b0) begin
      errors++; $display("FAIL idle_halted got halted=%b clk_en=%b want 1 0", halted, cpu.clk_en);
    end
    @(posedge clk_100M); #1;
  endtask

  task automatic test_lat3();
    int t_prev, n_en, pulses;
    cpu3.mem_addr = 32'h00400000; cpu3.w_data = '0; cpu3.wr_en = 1'b0;
    run3 = 1'b1;
    pulses = 0; n_en = 0; t_prev = 0;
    for (int i = 0; i < 40 && pulses < 4; i++) begin
      @(negedge clk_100M);
      if (ram_en3) n_en++;
      if (cpu3.clk_en) begin
        pulses++;
        checks++; if (cpu3.r_data !== 32'h20080005) begin errors++; $display("FAIL lat3_r_data got %h want 20080005", cpu3.r_data); end
        checks++; if (n_en !== 1) begin errors++; $display("FAIL lat3_ram_en_cycles got %0d want 1", n_en); end
        if (pulses > 1) begin
          checks++; if (cyc - t_prev !== 5) begin errors++; $display("FAIL lat3_period got %0d want 5", cyc - t_prev); end
        end
        n_en = 0; t_prev = cyc;
      end
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL lat3_pulses got %0d want 4", pulses); end
    run3 = 1'b0;
    repeat (8) @(posedge clk_100M);
    @(negedge clk_100M);
    checks++; if (halted3 !== 1'b1) begin errors++; $display("FAIL lat3_halt got %b want 1", halted3); end
    @(posedge clk_100M); #1;
  endtask

  task automatic test_first_fetch();
    logic [31:0] rd; logic [10:0] wa; int en_n, we_n, tc; logic seen;
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cpu_step(32'h00400000, 32'h0, 1'b0, 1'b0, rd, en_n, we_n, wa, tc, seen);
      model_commit(32'h00400000, 32'h0, 1'b0);
      checks++; if (!seen || rd !== 32'h20080005) begin errors++; $display("FAIL fetch_r_data got %h seen=%b want 20080005", rd, seen); end
      checks++; if (en_n !== 1 || we_n !== 0) begin errors++; $display("FAIL fetch_ram_en got en=%0d we=%0d want 1 0", en_n, we_n); end
      if (k > 0) begin
        checks++; if (tc - last_tick !== 3) begin errors++; $display("FAIL fetch_period got %0d want 3", tc - last_tick); end
      end
      last_tick = tc;
    end
  endtask

  task automatic test_mmio_led();
    logic [31:0] rd, exp_rd; logic [10:0] wa; int en_n, we_n, tc; logic seen;
    cpu_step(32'hFFFF0000, 32'h0000BEEF, 1'b1, 1'b0, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'hFFFF0000, 32'h0000BEEF, 1'b1);
    checks++; if (led !== 16'hBEEF) begin errors++; $display("FAIL led_store got %h want beef", led); end
    checks++; if (en_n !== 0 || we_n !== 0) begin errors++; $display("FAIL led_no_ram got en=%0d we=%0d want 0 0", en_n, we_n); end
    cpu_step(32'hFFFF0000, 32'h0, 1'b0, 1'b0, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'hFFFF0000, 32'h0, 1'b0);
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL led_readback got %h want 0000beef", rd); end
    // store and read of the same register in one step sees the old value
    exp_rd = model_read(32'hFFFF0000);
    cpu_step(32'hFFFF0000, 32'h00001234, 1'b1, 1'b0, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'hFFFF0000, 32'h00001234, 1'b1);
    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL led_pre_write got %h want %h", rd, exp_rd); end
    checks++; if (led !== 16'h1234) begin errors++; $display("FAIL led_second got %h want 1234", led); end
    last_tick = tc;
  endtask

  task automatic test_ram_store();
    logic [31:0] rd, exp_rd; logic [10:0] wa; int en_n, we_n, tc; logic seen;
    cpu_step(32'h10010004, 32'h12345678, 1'b1, 1'b0, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'h10010004, 32'h12345678, 1'b1);
    checks++; if (we_n !== 1 || wa !== 11'h401) begin errors++; $display("FAIL store_ram_addr got we=%0d addr=%h want 1 401", we_n, wa); end
    checks++; if (en_n !== 2) begin errors++; $display("FAIL store_ram_en got %0d want 2", en_n); end
    exp_rd = model_read(32'h00400004);
    cpu_step(32'h00400004, 32'h0, 1'b0, 1'b0, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'h00400004, 32'h0, 1'b0);
    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL text_alias got %h want %h", rd, exp_rd); end
    cpu_step(32'h10010004, 32'h0, 1'b0, 1'b0, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'h10010004, 32'h0, 1'b0);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL store_readback got %h want 12345678", rd); end
    last_tick = tc;
  endtask

  task automatic test_mmio_read();
    logic [31:0] rd, exp_rd; logic [10:0] wa; int en_n, we_n, tc; logic seen;
    logic [31:0] addrs [4];
    addrs[0] = 32'hFFFF0004; addrs[1] = 32'hFFFF0008; addrs[2] = 32'hFFFF000C; addrs[3] = 32'hFFFF0010;
    for (int k = 0; k < 4; k++) begin
      exp_rd = model_read(addrs[k]);
      cpu_step(addrs[k], 32'hFFFF_FFFF, 1'b1, 1'b0, rd, en_n, we_n, wa, tc, seen);
      model_commit(addrs[k], 32'hFFFF_FFFF, 1'b1);
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL mmio_read addr=%h got %h want %h", addrs[k], rd, exp_rd); end
      checks++; if (led !== led_m || en_n !== 0) begin errors++; $display("FAIL mmio_write_ignored got led=%h en=%0d want %h 0", led, en_n, led_m); end
    end
    last_tick = tc;
  endtask

  task automatic test_random();
    logic [31:0] a, wd, exp_rd, rd; logic we, seen, is_ram; logic [10:0] wa; int en_n, we_n, tc, exp_en;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h00400000 + (32'($urandom_range(0, 15)) << 2);
        1:       a = 32'h10010000 + (32'($urandom_range(0, 15)) << 2);
        2:       a = 32'hFFFF0000;
        3:       a = 32'hFFFF0004;
        4:       a = 32'hFFFF0008;
        default: a = 32'hFFFF0010;
      endcase
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      is_ram = (a < 32'hFFFF0000);
      exp_en = is_ram ? (we ? 2 : 1) : 0;
      exp_rd = model_read(a);
      cpu_step(a, wd, we, 1'b0, rd, en_n, we_n, wa, tc, seen);
      model_commit(a, wd, we);
      checks++; if (!seen || rd !== exp_rd) begin errors++; $display("FAIL rand_r_data addr=%h got %h want %h", a, rd, exp_rd); end
      checks++; if (en_n !== exp_en || we_n !== int'(is_ram && we)) begin
        errors++; $display("FAIL rand_ram_strobes addr=%h got en=%0d we=%0d want %0d %0d", a, en_n, we_n, exp_en, int'(is_ram && we));
      end
      checks++; if (led !== led_m) begin errors++; $display("FAIL rand_led got %h want %h", led, led_m); end
      checks++; if (tc - last_tick !== 3) begin errors++; $display("FAIL rand_period got %0d want 3", tc - last_tick); end
      last_tick = tc;
    end
  endtask

  task automatic test_single_step();
    logic [31:0] rd, exp_rd; logic [10:0] wa; int en_n, we_n, tc, n, h, total; logic seen;
    // run drops while a step is already under way: it still completes once
    run = 1'b0;
    exp_rd = model_read(32'hFFFF0004);
    cpu_step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'hFFFF0004, 32'h0, 1'b0);
    checks++; if (!seen || rd !== exp_rd) begin errors++; $display("FAIL run_drop_step got %h seen=%b want %h", rd, seen, exp_rd); end
    total = 0;
    for (int k = 0; k < 3; k++) begin
      h = 0; n = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk_100M);
        if (halted) h++;
        if (cpu.clk_en) total++;
      end
      checks++; if (h !== 10) begin errors++; $display("FAIL step_halted_between got %0d want 10", h); end
      @(posedge clk_100M); #1;
      exp_rd = model_read(32'hFFFF0008);
      cpu.mem_addr = 32'hFFFF0008; cpu.wr_en = 1'b0;
      // two-cycle high: second cycle lands in ACCESS and must not queue a step
      step = 1'b1;
      @(posedge clk_100M); #1;
      @(posedge clk_100M); #1;
      step = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk_100M);
        if (cpu.clk_en) begin n++; total++; rd = cpu.r_data; end
      end
      model_commit(32'hFFFF0008, 32'h0, 1'b0);
      checks++; if (n !== 1 || rd !== exp_rd) begin errors++; $display("FAIL step_one_pulse got n=%0d rd=%h want 1 %h", n, rd, exp_rd); end
      @(posedge clk_100M); #1;
    end
    checks++; if (total !== 3) begin errors++; $display("FAIL step_total got %0d want 3", total); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, exp_rd; logic [10:0] wa; int en_n, we_n, tc; logic seen;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_before got %b want 0", misalign); end
    exp_rd = model_read(32'h00400002);
    cpu_step(32'h00400002, 32'h0, 1'b0, 1'b1, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'h00400002, 32'h0, 1'b0);
    checks++; if (misalign !== 1'b1 || rd !== exp_rd) begin errors++; $display("FAIL misalign_set got %b rd=%h want 1 %h", misalign, rd, exp_rd); end
    cpu_step(32'h10010004, 32'h0, 1'b0, 1'b1, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'h10010004, 32'h0, 1'b0);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky got %b want 1", misalign); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, exp_rd; logic [10:0] wa; int en_n, we_n, tc; logic seen;
    cpu_step(32'hFFFF0000, 32'h000000A5, 1'b1, 1'b1, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'hFFFF0000, 32'h000000A5, 1'b1);
    checks++; if (led !== 16'h00A5) begin errors++; $display("FAIL pre_reset_led got %h want 00a5", led); end
    cpu.mem_addr = 32'h10010008; cpu.w_data = 32'hCAFE0001; cpu.wr_en = 1'b1;
    step = 1'b1;
    @(posedge clk_100M); #1;
    step = 1'b0;
    @(posedge clk_100M); #1;
    rst = 1'b0;
    #1;
    checks++; if (cpu.clk_en !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL midwait_fsm got clk_en=%b halted=%b want 0 1", cpu.clk_en, halted); end
    checks++; if (led !== 16'h0 || misalign !== 1'b0) begin errors++; $display("FAIL midwait_regs got led=%h misalign=%b want 0000 0", led, misalign); end
    checks++; if (cpu.r_data !== 32'h0 || ram_en !== 1'b0) begin errors++; $display("FAIL midwait_bus got r_data=%h ram_en=%b want 0 0", cpu.r_data, ram_en); end
    @(posedge clk_100M); #1;
    rst = 1'b1;
    led_m = '0; tick_m = '0;
    exp_rd = model_read(32'h10010008);
    cpu_step(32'h10010008, 32'h0, 1'b0, 1'b1, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'h10010008, 32'h0, 1'b0);
    checks++; if (!seen || rd !== exp_rd) begin errors++; $display("FAIL lost_write got %h want %h", rd, exp_rd); end
    exp_rd = model_read(32'hFFFF0008);
    cpu_step(32'hFFFF0008, 32'h0, 1'b0, 1'b1, rd, en_n, we_n, wa, tc, seen);
    model_commit(32'hFFFF0008, 32'h0, 1'b0);
    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL tick_after_reset got %h want %h", rd, exp_rd); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]  = 32'h0;
      ram3[i] = 32'h0;
    end
    ram[0]  = 32'h20080005;
    ram3[0] = 32'h20080005;
    mdl[32'h00400000] = 32'h20080005;
    test_reset();
    test_lat3();
    test_first_fetch();
    test_mmio_led();
    test_ram_store();
    test_mmio_read();
    test_random();
    test_single_step();
    test_misalign();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
